// File: rtl/load_store_unit_pkg.sv
// Shared types for the rv32I data-memory port: width codes, FSM states and the memory command payload.
package load_store_unit_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned BE_W = XLEN / 8;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } ls_width_t;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      RESP
   } lsu_state_t;

   typedef struct packed {
      logic            we;
      logic [XLEN-1:0] addr;
      logic [BE_W-1:0] be;
      logic [XLEN-1:0] wdata;
   } mem_cmd_t;

   // Stores only have byte/half/word codes; the unsigned codes exist for loads only.
   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      case (f3)
         3'b000, 3'b001, 3'b010: return 1'b1;
         3'b100, 3'b101:         return !we;
         default:                return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the load/store unit: byte enables, store replication,
// load extraction with sign/zero extension, and alignment/legality checks.
module lsu_align
   import load_store_unit_pkg::*;
(
   input  logic            we,
   input  logic [2:0]      funct3,
   input  logic [1:0]      addr_lo,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rdata,
   output logic [BE_W-1:0] be_c,
   output logic [XLEN-1:0] wdata_c,
   output logic [XLEN-1:0] rdata_c,
   output logic            misalign_c,
   output logic            illegal_c
);

   logic [XLEN-1:0] lane;

   assign lane = rdata >> {addr_lo, 3'b000};

   always_comb begin
      be_c       = '0;
      wdata_c    = wdata;
      rdata_c    = lane;
      misalign_c = 1'b0;
      illegal_c  = !f3_legal(we, funct3);
      // funct3[2] distinguishes the zero-extending variants
      case (funct3)
         LB, LBU: begin
            be_c    = 4'b0001 << addr_lo;
            wdata_c = {4{wdata[7:0]}};
            rdata_c = {{24{lane[7] & ~funct3[2]}}, lane[7:0]};
         end
         LH, LHU: begin
            misalign_c = addr_lo[0];
            be_c       = 4'b0011 << addr_lo;
            wdata_c    = {2{wdata[15:0]}};
            rdata_c    = {{16{lane[15] & ~funct3[2]}}, lane[15:0]};
         end
         LW: begin
            misalign_c = (addr_lo != 2'b00);
            be_c       = 4'b1111;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory port of the rv32I core: accepts one LOAD/STORE from execute and runs
// it over a req/gnt/rvalid word-addressed memory interface with a timeout.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_rdata,
   output logic            resp_err,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [BE_W-1:0] mem_be,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_gnt,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata
);

   lsu_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   mem_cmd_t        cmd_q, cmd_d;
   logic [2:0]      f3_q, f3_d;
   logic [1:0]      lo_q, lo_d;
   logic [XLEN-1:0] rdata_d;
   logic            err_d;
   logic            timeout;

   logic            al_we;
   logic [2:0]      al_f3;
   logic [1:0]      al_lo;
   logic [BE_W-1:0] al_be;
   logic [XLEN-1:0] al_wdata;
   logic [XLEN-1:0] al_rdata;
   logic            al_misalign;
   logic            al_illegal;

   // Aligner sees the live request while idle, the captured one afterwards
   assign al_we = (state_q == IDLE) ? req_we         : cmd_q.we;
   assign al_f3 = (state_q == IDLE) ? req_funct3     : f3_q;
   assign al_lo = (state_q == IDLE) ? req_addr[1:0]  : lo_q;

   lsu_align u_align (
      .we         (al_we),
      .funct3     (al_f3),
      .addr_lo    (al_lo),
      .wdata      (req_wdata),
      .rdata      (mem_rdata),
      .be_c       (al_be),
      .wdata_c    (al_wdata),
      .rdata_c    (al_rdata),
      .misalign_c (al_misalign),
      .illegal_c  (al_illegal)
   );

   assign timeout   = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign mem_we    = cmd_q.we;
   assign mem_addr  = cmd_q.addr;
   assign mem_be    = cmd_q.be;
   assign mem_wdata = cmd_q.wdata;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cmd_d   = cmd_q;
      f3_d    = f3_q;
      lo_d    = lo_q;
      rdata_d = resp_rdata;
      err_d   = resp_err;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               f3_d = req_funct3;
               lo_d = req_addr[1:0];
               if (al_illegal || al_misalign) begin
                  state_d = RESP;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end else begin
                  state_d = REQ;
                  cnt_d   = '0;
                  cmd_d   = '{we: req_we, addr: {req_addr[XLEN-1:2], 2'b00},
                              be: al_be, wdata: al_wdata};
               end
            end
         end
         REQ: begin
            // grant and data in the same cycle completes the access directly
            if (mem_gnt && mem_rvalid) begin
               state_d = RESP;
               err_d   = 1'b0;
               rdata_d = cmd_q.we ? '0 : al_rdata;
            end else if (mem_gnt) begin
               state_d = WAIT;
               cnt_d   = '0;
            end else if (timeout) begin
               state_d = RESP;
               err_d   = 1'b1;
               rdata_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WAIT: begin
            if (mem_rvalid) begin
               state_d = RESP;
               err_d   = 1'b0;
               rdata_d = cmd_q.we ? '0 : al_rdata;
            end else if (timeout) begin
               state_d = RESP;
               err_d   = 1'b1;
               rdata_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         cmd_q      <= '0;
         f3_q       <= '0;
         lo_q       <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         mem_req    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cmd_q      <= cmd_d;
         f3_q       <= f3_d;
         lo_q       <= lo_d;
         req_ready  <= (state_d == IDLE);
         resp_valid <= (state_d == RESP);
         resp_rdata <= rdata_d;
         resp_err   <= err_d;
         mem_req    <= (state_d == REQ);
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: lane handling, latency, error paths, timeout and reset.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT_CYCLES(255), .CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one request at the next negedge; returns after the accepting posedge + half cycle,
   // with req_* scrambled so later changes can be shown to have no effect.
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd);
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      mem_rdata  = rd;
      @(posedge clk);
      @(negedge clk);
      req_valid  = 1'b0;
      req_we     = ~we;
      req_funct3 = 3'b111;
      req_addr   = 32'hFFFF_FFFF;
      req_wdata  = 32'h5555_5555;
   endtask

   // Zero-wait access: gnt in REQ, rvalid the following cycle; resp_valid seen before edge T+3.
   task automatic access(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd, input logic [31:0] exp_rd);
      issue(we, f3, addr, wd, rd);
      check({tag, ".mem_req"},   32'(mem_req), 32'd1);
      check({tag, ".mem_addr"},  mem_addr, exp_addr);
      check({tag, ".mem_be"},    32'(mem_be), 32'(exp_be));
      check({tag, ".mem_we"},    32'(mem_we), 32'(we));
      if (we) check({tag, ".mem_wdata"}, mem_wdata, exp_wd);
      check({tag, ".req_ready"}, 32'(req_ready), 32'd0);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b1;
      check({tag, ".mem_req_drop"}, 32'(mem_req), 32'd0);
      check({tag, ".early_resp"},   32'(resp_valid), 32'd0);
      @(negedge clk);
      mem_rvalid = 1'b0;
      check({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
      check({tag, ".resp_err"},   32'(resp_err), 32'd0);
      check({tag, ".resp_rdata"}, resp_rdata, exp_rd);
      @(negedge clk);
      check({tag, ".resp_pulse"}, 32'(resp_valid), 32'd0);
      check({tag, ".ready_again"}, 32'(req_ready), 32'd1);
   endtask

   // Rejected access: no memory request, error response one cycle after acceptance.
   task automatic reject(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr);
      issue(we, f3, addr, 32'hCAFE_F00D, 32'h1234_5678);
      check({tag, ".mem_req"},    32'(mem_req), 32'd0);
      check({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
      check({tag, ".resp_err"},   32'(resp_err), 32'd1);
      check({tag, ".resp_rdata"}, resp_rdata, 32'd0);
      @(negedge clk);
      check({tag, ".resp_pulse"}, 32'(resp_valid), 32'd0);
      check({tag, ".mem_req2"},   32'(mem_req), 32'd0);
   endtask

   initial begin
      int  req_cycles;
      logic seen;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = '0;
      req_wdata  = '0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;

      repeat (2) @(negedge clk);
      check("rst.req_ready",  32'(req_ready), 32'd1);
      check("rst.resp_valid", 32'(resp_valid), 32'd0);
      check("rst.resp_rdata", resp_rdata, 32'd0);
      check("rst.resp_err",   32'(resp_err), 32'd0);
      check("rst.mem_req",    32'(mem_req), 32'd0);
      check("rst.mem_we",     32'(mem_we), 32'd0);
      check("rst.mem_addr",   mem_addr, 32'd0);
      check("rst.mem_be",     32'(mem_be), 32'd0);
      check("rst.mem_wdata",  mem_wdata, 32'd0);
      rst_n = 1'b1;

      access("lw",  1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF,
             32'h0000_0100, 4'b1111, 32'h0, 32'hDEAD_BEEF);
      access("lb",  1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_0000,
             32'h0000_0100, 4'b1000, 32'h0, 32'hFFFF_FF80);
      access("lbu", 1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_0000,
             32'h0000_0100, 4'b1000, 32'h0, 32'h0000_0080);
      access("lhu", 1'b0, 3'b101, 32'h0000_0100, 32'h0, 32'h1234_F00D,
             32'h0000_0100, 4'b0011, 32'h0, 32'h0000_F00D);
      access("lb1", 1'b0, 3'b000, 32'h0000_0011, 32'h0, 32'h0000_7F00,
             32'h0000_0010, 4'b0010, 32'h0, 32'h0000_007F);
      access("sh",  1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0,
             32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'h0);
      access("sb",  1'b1, 3'b000, 32'h0000_0301, 32'h0000_115A, 32'hFFFF_FFFF,
             32'h0000_0300, 4'b0010, 32'h5A5A_5A5A, 32'h0);
      access("sw",  1'b1, 3'b010, 32'h0000_0404, 32'h8765_4321, 32'hFFFF_FFFF,
             32'h0000_0404, 4'b1111, 32'h8765_4321, 32'h0);

      reject("lw_mis",  1'b0, 3'b010, 32'h0000_0101);
      reject("lh_mis",  1'b0, 3'b001, 32'h0000_0103);
      reject("sw_mis",  1'b1, 3'b010, 32'h0000_0102);
      reject("ill_f3",  1'b0, 3'b011, 32'h0000_0100);
      reject("ill_st",  1'b1, 3'b100, 32'h0000_0100);

      // grant and data in the same REQ cycle
      issue(1'b0, 3'b001, 32'h0000_0502, 32'h0, 32'h8001_0000);
      mem_gnt    = 1'b1;
      mem_rvalid = 1'b1;
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      check("lh_fast.resp_valid", 32'(resp_valid), 32'd1);
      check("lh_fast.resp_err",   32'(resp_err), 32'd0);
      check("lh_fast.resp_rdata", resp_rdata, 32'hFFFF_8001);
      @(negedge clk);
      check("lh_fast.pulse", 32'(resp_valid), 32'd0);

      // grant withheld: abort after 255 cycles of mem_req
      issue(1'b0, 3'b010, 32'h0000_0600, 32'h0, 32'h0);
      req_cycles = 0;
      seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (resp_valid) begin
            seen = 1'b1;
            break;
         end
         if (mem_req) req_cycles++;
         @(negedge clk);
      end
      check("tmo.resp_seen",  32'(seen), 32'd1);
      check("tmo.req_cycles", 32'(req_cycles), 32'd255);
      check("tmo.mem_req",    32'(mem_req), 32'd0);
      check("tmo.resp_err",   32'(resp_err), 32'd1);
      check("tmo.resp_rdata", resp_rdata, 32'd0);
      @(negedge clk);
      mem_rvalid = 1'b1;
      mem_gnt    = 1'b1;
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_gnt    = 1'b0;
      check("tmo.late_rvalid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      check("tmo.late_rvalid2", 32'(resp_valid), 32'd0);
      access("after_tmo", 1'b0, 3'b010, 32'h0000_0700, 32'h0, 32'h0BAD_F00D,
             32'h0000_0700, 4'b1111, 32'h0, 32'h0BAD_F00D);

      // reset while waiting for read data
      issue(1'b0, 3'b010, 32'h0000_0800, 32'h0, 32'h1111_2222);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      rst_n   = 1'b0;
      #1;
      check("rstw.req_ready",  32'(req_ready), 32'd1);
      check("rstw.resp_valid", 32'(resp_valid), 32'd0);
      check("rstw.resp_rdata", resp_rdata, 32'd0);
      check("rstw.mem_req",    32'(mem_req), 32'd0);
      check("rstw.mem_addr",   mem_addr, 32'd0);
      check("rstw.mem_be",     32'(mem_be), 32'd0);
      @(negedge clk);
      rst_n      = 1'b1;
      mem_rvalid = 1'b1;
      @(negedge clk);
      mem_rvalid = 1'b0;
      check("rstw.late_rvalid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      check("rstw.late_rvalid2", 32'(resp_valid), 32'd0);
      check("rstw.idle_ready",   32'(req_ready), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
